multicycle_control_unit: RTL and testbench

- Moore-style control FSM for the multicycle MIPS core. It sits directly upstream of the datapath.
- Consumes the op/funct fields decoded from the instruction register.
- Each cycle, produces the full control-signal set that steers PC update, memory, IR load, register file, ALU mux selects and ALU function.
- Also latches external interrupt requests and redirects the next instruction fetch to the interrupt vector.

---
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: Moore-style control signals per state, illegal-op
// flag in DECODE, and a latched interrupt that redirects the next instruction fetch.
module multicycle_control_unit #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       intReq,
    output logic [1:0] aluControl,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic       pcWrite,
    output logic       isBranch,
    output logic       lorD,
    output logic       memWrite,
    output logic       IrWrite,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       isInterrupted,
    output logic       intAck,
    output logic       illegalOp,
    output logic [3:0] state
);

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       int_pending_reg;
    logic       int_pending_next;
    logic       funct_legal;
    logic       rtype_legal;
    logic       op_legal;
    logic [1:0] funct_alu;

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = 2'b00;
        case (funct)
            FN_ADD:  funct_alu = 2'b00;
            FN_SUB:  funct_alu = 2'b01;
            FN_AND:  funct_alu = 2'b10;
            FN_OR:   funct_alu = 2'b11;
            default: funct_legal = 1'b0;
        endcase
    end

    assign rtype_legal = (op == OP_RTYPE) && funct_legal;
    assign op_legal    = rtype_legal || (op == OP_LW) || (op == OP_SW) ||
                         (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg       <= S_IDLE;
            int_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            int_pending_reg <= int_pending_next;
        end
    end

    // A new request on the same edge as the serviced fetch keeps the interrupt pending.
    always_comb begin
        int_pending_next = int_pending_reg;
        if (intReq)
            int_pending_next = 1'b1;
        else if (state_reg == S_FETCH)
            int_pending_next = 1'b0;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if ((op == OP_LW) || (op == OP_SW)) state_next = S_MEMADR;
                else if (rtype_legal)               state_next = S_EXECUTE;
                else if (op == OP_BEQ)              state_next = S_BRANCH;
                else if (op == OP_ADDI)             state_next = S_ADDIEXEC;
                else if (op == OP_J)                state_next = S_JUMP;
                else                                state_next = S_FETCH;
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_next = S_MEMREAD;
                else if (op == OP_SW) state_next = S_MEMWRITE;
                else                  state_next = S_FETCH;
            end
            S_MEMREAD:  state_next = S_MEMWB;
            S_EXECUTE:  state_next = S_ALUWB;
            S_ADDIEXEC: state_next = S_ADDIWB;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        aluControl    = 2'b00;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        pcSource      = 2'b00;
        pcWrite       = 1'b0;
        isBranch      = 1'b0;
        lorD          = 1'b0;
        memWrite      = 1'b0;
        IrWrite       = 1'b0;
        regWrite      = 1'b0;
        regDst        = 1'b0;
        memToReg      = 1'b0;
        isInterrupted = 1'b0;
        intAck        = 1'b0;
        illegalOp     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                aluSrcB       = 2'b01;
                IrWrite       = 1'b1;
                pcWrite       = 1'b1;
                isInterrupted = int_pending_reg;
                intAck        = int_pending_reg;
            end
            S_DECODE: begin
                aluSrcB   = 2'b11;
                illegalOp = !op_legal;
            end
            S_MEMADR, S_ADDIEXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMREAD: lorD = 1'b1;
            S_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
            end
            S_MEMWRITE: begin
                lorD     = 1'b1;
                memWrite = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA    = 1'b1;
                aluControl = funct_alu;
            end
            S_ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            S_ADDIWB: regWrite = 1'b1;
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluControl = 2'b01;
                pcSource   = 2'b01;
                isBranch   = 1'b1;
            end
            S_JUMP: begin
                pcSource = 2'b10;
                pcWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level model (state path per
// opcode, output table per state, pending-interrupt bit) checked every cycle.
module tb_multicycle_control_unit;

    localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, ADDI = 6'h08, J = 6'h02;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       intReq = 1'b0;
    logic [1:0] aluControl, aluSrcB, pcSource;
    logic       aluSrcA, pcWrite, isBranch, lorD, memWrite, IrWrite, regWrite;
    logic       regDst, memToReg, isInterrupted, intAck, illegalOp;
    logic [3:0] state;

    multicycle_control_unit dut (
        .clk(clk), .resetN(resetN), .op(op), .funct(funct), .intReq(intReq),
        .aluControl(aluControl), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSource(pcSource),
        .pcWrite(pcWrite), .isBranch(isBranch), .lorD(lorD), .memWrite(memWrite),
        .IrWrite(IrWrite), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
        .isInterrupted(isInterrupted), .intAck(intAck), .illegalOp(illegalOp), .state(state)
    );

    always #5 clk = ~clk;

    // Packed view: [21:20] aluControl [19] aluSrcA [18:17] aluSrcB [16:15] pcSource
    // [14] pcWrite [13] isBranch [12] lorD [11] memWrite [10] IrWrite [9] regWrite
    // [8] regDst [7] memToReg [6] isInterrupted [5] intAck [4] illegalOp [3:0] state
    logic [21:0] dut_vec;
    assign dut_vec = {aluControl, aluSrcA, aluSrcB, pcSource, pcWrite, isBranch, lorD, memWrite,
                      IrWrite, regWrite, regDst, memToReg, isInterrupted, intAck, illegalOp, state};

    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          exp_q[$];
    logic        pend = 1'b0;
    logic        release_now = 1'b0;
    logic [21:0] seen_vec[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25);
    endfunction

    function automatic logic [1:0] alu_of(input logic [5:0] f);
        case (f)
            6'h22:   return 2'b01;
            6'h24:   return 2'b10;
            6'h25:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic instr_ok(input logic [5:0] o, input logic [5:0] f);
        return (o == RT && funct_ok(f)) || o == LW || o == SW || o == BEQ || o == ADDI || o == J;
    endfunction

    // Required output bundle for a state, read off the per-state control table.
    function automatic logic [21:0] exp_vec(input int st, input logic [5:0] o, input logic [5:0] f,
                                            input logic p);
        logic [21:0] v;
        v = '0;
        v[3:0] = st[3:0];
        case (st)
            1:  begin v[18:17] = 2'b01; v[10] = 1'b1; v[14] = 1'b1; v[6] = p; v[5] = p; end
            2:  begin v[18:17] = 2'b11; v[4] = !instr_ok(o, f); end
            3, 10: begin v[19] = 1'b1; v[18:17] = 2'b10; end
            4:  v[12] = 1'b1;
            5:  begin v[7] = 1'b1; v[9] = 1'b1; end
            6:  begin v[12] = 1'b1; v[11] = 1'b1; end
            7:  begin v[19] = 1'b1; v[21:20] = alu_of(f); end
            8:  begin v[8] = 1'b1; v[9] = 1'b1; end
            9:  begin v[19] = 1'b1; v[21:20] = 2'b01; v[16:15] = 2'b01; v[13] = 1'b1; end
            11: v[9] = 1'b1;
            12: begin v[16:15] = 2'b10; v[14] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic push_path(input logic [5:0] o, input logic [5:0] f);
        exp_q.push_back(1);
        exp_q.push_back(2);
        if (o == LW) begin exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(5); end
        else if (o == SW) begin exp_q.push_back(3); exp_q.push_back(6); end
        else if (o == RT && funct_ok(f)) begin exp_q.push_back(7); exp_q.push_back(8); end
        else if (o == BEQ) exp_q.push_back(9);
        else if (o == ADDI) begin exp_q.push_back(10); exp_q.push_back(11); end
        else if (o == J) exp_q.push_back(12);
    endtask

    task automatic run_cycle(input logic [5:0] o, input logic [5:0] f, input logic ireq);
        int st;
        @(negedge clk);
        if (release_now) begin
            resetN = 1'b1;
            release_now = 1'b0;
        end
        op = o;
        funct = f;
        intReq = ireq;
        #1;
        cycle++;
        if (exp_q.size() == 0) begin
            check("model_queue_empty", 32'd1, 32'd0);
            st = 1;
        end else begin
            st = exp_q.pop_front();
        end
        seen_vec[st] = dut_vec;
        check($sformatf("cyc%0d_state%0d", cycle, st), {10'd0, dut_vec}, {10'd0, exp_vec(st, o, f, pend)});
        if (ireq) pend = 1'b1;
        else if (st == 1) pend = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic [7:0] irq_mask);
        int n;
        push_path(o, f);
        n = exp_q.size();
        for (int i = 0; i < n; i++) run_cycle(o, f, irq_mask[i]);
        $display("instr op=%h funct=%h cycles=%0d irq_mask=%b", o, f, n, irq_mask);
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[4];
        logic [5:0] ro, rf;
        logic [7:0] rm;
        ops[0] = RT; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = ADDI; ops[5] = J;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25;

        // Reset and first fetch
        repeat (2) @(negedge clk);
        #1;
        check("in_reset_outputs", {10'd0, dut_vec}, 32'd0);
        release_now = 1'b1;
        exp_q.push_back(0);
        run_cycle(6'h00, 6'h00, 1'b0);
        check("idle_outputs", {10'd0, seen_vec[0]}, 32'd0);

        // lw then sw
        run_instr(LW, 6'h00, 8'h00);
        check("fetch_pcwrite", seen_vec[1][14], 1);
        check("fetch_irwrite", seen_vec[1][10], 1);
        check("fetch_alusrcb", seen_vec[1][18:17], 2'b01);
        check("fetch_state", seen_vec[1][3:0], 4'd1);
        check("lw_memwb_memtoreg", seen_vec[5][7], 1);
        check("lw_memwb_regwrite", seen_vec[5][9], 1);
        check("lw_memread_lord", seen_vec[4][12], 1);
        run_instr(SW, 6'h00, 8'h00);
        check("sw_memwrite", seen_vec[6][11], 1);
        check("sw_lord", seen_vec[6][12], 1);

        // R-type funct sweep and illegal funct
        for (int k = 0; k < 4; k++) begin
            run_instr(RT, fns[k], 8'h00);
            check($sformatf("rtype_alu_%h", fns[k]), seen_vec[7][21:20], k[1:0]);
            check("aluwb_regdst", seen_vec[8][8], 1);
        end
        run_instr(RT, 6'h2A, 8'h00);
        check("illegal_funct_flag", seen_vec[2][4], 1);

        // beq, j, addi
        run_instr(BEQ, 6'h00, 8'h00);
        check("beq_isbranch", seen_vec[9][13], 1);
        check("beq_pcsource", seen_vec[9][16:15], 2'b01);
        check("beq_sub", seen_vec[9][21:20], 2'b01);
        run_instr(J, 6'h00, 8'h00);
        check("j_pcwrite", seen_vec[12][14], 1);
        check("j_pcsource", seen_vec[12][16:15], 2'b10);
        run_instr(ADDI, 6'h00, 8'h00);
        check("addiwb_regwrite", seen_vec[11][9], 1);
        check("addiwb_regdst", seen_vec[11][8], 0);
        check("legal_decode_no_flag", seen_vec[2][4], 0);

        // Interrupt pulsed during EXECUTE
        run_instr(RT, 6'h20, 8'b0000_0100);
        check("rtype_completes_alu", seen_vec[8][3:0], 4'd8);
        run_instr(J, 6'h00, 8'h00);
        check("irq_fetch_taken", seen_vec[1][6:5], 2'b11);
        run_instr(ADDI, 6'h00, 8'h00);
        check("irq_fetch_cleared", seen_vec[1][6:5], 2'b00);

        // Request held through the interrupted fetch
        run_instr(BEQ, 6'h00, 8'b0000_0100);
        run_instr(J, 6'h00, 8'b0000_0001);
        check("hold_first_int", seen_vec[1][6], 1);
        run_instr(ADDI, 6'h00, 8'h00);
        check("hold_second_int", seen_vec[1][6], 1);
        run_instr(J, 6'h00, 8'h00);
        check("hold_then_clear", seen_vec[1][6], 0);

        // Asynchronous reset in the middle of MEMWRITE, with an interrupt pending
        push_path(SW, 6'h00);
        run_cycle(SW, 6'h00, 1'b0);
        run_cycle(SW, 6'h00, 1'b0);
        run_cycle(SW, 6'h00, 1'b1);
        run_cycle(SW, 6'h00, 1'b0);
        check("pre_reset_memwrite", seen_vec[6][11], 1);
        #1 resetN = 1'b0;
        #1;
        check("async_reset_memwrite", memWrite, 0);
        check("async_reset_state", state, 4'd0);
        check("async_reset_all", {10'd0, dut_vec}, 32'd0);
        $display("async reset asserted in MEMWRITE");
        exp_q.delete();
        pend = 1'b0;
        repeat (2) @(posedge clk);
        release_now = 1'b1;
        exp_q.push_back(0);
        run_cycle(6'h00, 6'h00, 1'b0);
        run_instr(ADDI, 6'h00, 8'h00);
        check("reset_clears_pending", seen_vec[1][6], 0);

        // Randomized instruction stream with random interrupt requests
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) ro = 6'($urandom_range(0, 63));
            else ro = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) rf = 6'($urandom_range(0, 63));
            else rf = fns[$urandom_range(0, 3)];
            rm = '0;
            for (int b = 0; b < 8; b++) rm[b] = ($urandom_range(0, 7) == 0);
            run_instr(ro, rf, rm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
